ddc: RTL and testbench

Digital down converter: the receive-side counterpart of the DUC. It mixes a real 16-bit sample stream at the system clock rate against an internal NCO to produce complex baseband. It then decimates by an integrate-and-dump stage and presents I/Q pairs on a valid/ready output. It sits between the ADC capture logic and the baseband demodulator.

---
 rtl/ddc_pkg.sv | 37 +++
 rtl/ddc_nco.sv | 44 ++++
 rtl/ddc.sv | 132 +++++++++++++
 tb/tb_ddc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// ddc_pkg: shared constants for the down converter -- sample/LUT widths,
// the 256-entry cosine table and the sine address helper.
package ddc_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned LUT_AW     = 8;
  localparam int unsigned LUT_DEPTH  = 256;
  localparam int unsigned SIN_OFFSET = 192;

  typedef logic [LUT_DEPTH-1:0][SAMPLE_W-1:0] cos_lut_t;

  // Evaluated at elaboration only; the result is a plain constant ROM.
  function automatic cos_lut_t build_cos_lut();
    cos_lut_t    lut;
    real         r;
    int unsigned k;
    lut = '0;
    for (int unsigned hi = 0; hi < 16; hi++) begin
      for (int unsigned lo = 0; lo < 16; lo++) begin
        k = hi * 16 + lo;
        r = 32767.0 * $cos(2.0 * 3.14159265358979323846 * $itor(k) / 256.0);
        if (r >= 0.0)
          lut[k[LUT_AW-1:0]] = SAMPLE_W'($rtoi(r + 0.5));
        else
          lut[k[LUT_AW-1:0]] = SAMPLE_W'(-$rtoi(0.5 - r));
      end
    end
    return lut;
  endfunction

  localparam cos_lut_t COS_LUT = build_cos_lut();

  function automatic logic [LUT_AW-1:0] sin_addr(input logic [LUT_AW-1:0] cos_addr);
    return cos_addr + LUT_AW'(SIN_OFFSET);
  endfunction

endpackage

// File: rtl/ddc_nco.sv
// ddc_nco: phase accumulator plus cosine/sine table lookup, one registered
// cos/sin pair per accepted sample.
module ddc_nco
  import ddc_pkg::*;
#(
  parameter int unsigned PHASE_W = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [PHASE_W-1:0]         phase_inc,
  output logic                       lut_valid,
  output logic signed [SAMPLE_W-1:0] cos_val,
  output logic signed [SAMPLE_W-1:0] sin_val
);

  logic [PHASE_W-1:0] phase;
  logic [LUT_AW-1:0]  addr;

  assign addr = phase[PHASE_W-1 -: LUT_AW];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      lut_valid <= 1'b0;
      cos_val   <= '0;
      sin_val   <= '0;
    end else if (clr) begin
      phase     <= '0;
      lut_valid <= 1'b0;
      cos_val   <= '0;
      sin_val   <= '0;
    end else begin
      lut_valid <= in_valid;
      if (in_valid) begin
        phase   <= phase + phase_inc;
        cos_val <= COS_LUT[addr];
        sin_val <= COS_LUT[sin_addr(addr)];
      end
    end
  end

endmodule

// File: rtl/ddc.sv
// ddc: real-to-complex digital down converter (NCO mix, integrate-and-dump).
// Define DDC_ROUND_EN for round-half-up in mixer and decimator instead of truncation.
module ddc
  import ddc_pkg::*;
#(
  parameter int unsigned DECIM   = 4,
  parameter int unsigned PHASE_W = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [PHASE_W-1:0]         phase_inc,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] rf_input,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] i_out,
  output logic signed [SAMPLE_W-1:0] q_out,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned DEC_SH = $clog2(DECIM);
  localparam int unsigned ACC_W  = SAMPLE_W + DEC_SH;
  localparam int unsigned PROD_W = 2 * SAMPLE_W;

`ifdef DDC_ROUND_EN
  localparam logic signed [PROD_W-1:0] MIX_RND = PROD_W'(1 << (SAMPLE_W - 2));
  localparam logic signed [ACC_W:0]    DEC_RND = (ACC_W+1)'(1 << (DEC_SH - 1));
`else
  localparam logic signed [PROD_W-1:0] MIX_RND = '0;
  localparam logic signed [ACC_W:0]    DEC_RND = '0;
`endif

  logic                       s1_valid, s2_valid;
  logic signed [SAMPLE_W-1:0] cos_val, sin_val, s1_x;
  logic signed [PROD_W-1:0]   prod_i, prod_q;
  logic signed [SAMPLE_W-1:0] mix_i_d, mix_q_d, mix_i, mix_q;
  logic signed [ACC_W-1:0]    acc_i, acc_q, sum_i, sum_q;
  logic signed [ACC_W:0]      tot_i, tot_q;
  logic signed [SAMPLE_W-1:0] res_i, res_q;
  logic [DEC_SH-1:0]          cnt;
  logic                       dump, drop;

  ddc_nco #(.PHASE_W(PHASE_W)) u_nco (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .phase_inc (phase_inc),
    .lut_valid (s1_valid),
    .cos_val   (cos_val),
    .sin_val   (sin_val)
  );

  // Q is negated before the shift so both channels floor the same way.
  always_comb begin
    prod_i  = PROD_W'(s1_x) * PROD_W'(cos_val);
    prod_q  = -(PROD_W'(s1_x) * PROD_W'(sin_val));
    mix_i_d = SAMPLE_W'((prod_i + MIX_RND) >>> (SAMPLE_W - 1));
    mix_q_d = SAMPLE_W'((prod_q + MIX_RND) >>> (SAMPLE_W - 1));
    sum_i   = acc_i + ACC_W'(mix_i);
    sum_q   = acc_q + ACC_W'(mix_q);
    tot_i   = (ACC_W+1)'(sum_i) + DEC_RND;
    tot_q   = (ACC_W+1)'(sum_q) + DEC_RND;
    res_i   = SAMPLE_W'(tot_i >>> DEC_SH);
    res_q   = SAMPLE_W'(tot_q >>> DEC_SH);
    dump    = s2_valid && (cnt == DEC_SH'(DECIM - 1));
    drop    = dump && out_valid && !out_ready;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x     <= '0;
      s2_valid <= 1'b0;
      mix_i    <= '0;
      mix_q    <= '0;
    end else if (clr) begin
      s1_x     <= '0;
      s2_valid <= 1'b0;
      mix_i    <= '0;
      mix_q    <= '0;
    end else begin
      if (in_valid) s1_x <= rf_input;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        mix_i <= mix_i_d;
        mix_q <= mix_q_d;
      end
    end
  end

  // The dumping sample is folded into the result; the next block starts from zero.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (s2_valid) begin
        if (dump) begin
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + 1'b1;
        end
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (dump && !drop) begin
        i_out     <= res_i;
        q_out     <= res_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddc.sv
// tb_ddc: directed plus randomised scoreboard bench for the ddc down converter.
`timescale 1ns/1ps
module tb_ddc;

  localparam int unsigned DECIM   = 4;
  localparam int unsigned PHASE_W = 32;
  localparam int          SH      = $clog2(DECIM);

`ifdef DDC_ROUND_EN
  localparam int DC_I = 16384;
  localparam int FS_I = 0;
  localparam int FS_Q = 0;
`else
  localparam int DC_I = 16383;
  localparam int FS_I = -1;
  localparam int FS_Q = -1;
`endif
  localparam int NEG_I = -8192;

  logic                 sys_clk   = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 clr       = 1'b0;
  logic [PHASE_W-1:0]   phase_inc = '0;
  logic                 in_valid  = 1'b0;
  logic signed [15:0]   rf_input  = '0;
  logic                 out_ready = 1'b1;
  logic                 ovf_clr   = 1'b0;
  logic                 out_valid;
  logic signed [15:0]   i_out, q_out;
  logic                 overflow;

  ddc #(.DECIM(DECIM), .PHASE_W(PHASE_W)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .phase_inc (phase_inc),
    .in_valid  (in_valid),
    .rf_input  (rf_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .i_out     (i_out),
    .q_out     (q_out),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } pair_t;

  pair_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    n_out    = 0;

  logic [PHASE_W-1:0] m_phase;
  longint             m_acc_i, m_acc_q;
  int                 m_cnt;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int ei, input int eq);
    pair_t e;
    e.i = 16'(ei);
    e.q = 16'(eq);
    exp_q.push_back(e);
  endtask

  function automatic int ref_cos(input int k);
    real r;
    r = 32767.0 * $cos(2.0 * 3.141592653589793 * $itor(k) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  task automatic model_step(input logic signed [15:0] x);
    int     a, c, s;
    longint pi, pq;
    a  = int'(m_phase[PHASE_W-1 -: 8]);
    c  = ref_cos(a);
    s  = ref_cos((a + 192) % 256);
    pi = longint'(x) * c;
    pq = -(longint'(x) * s);
`ifdef DDC_ROUND_EN
    pi += 16384;
    pq += 16384;
`endif
    m_acc_i += pi >>> 15;
    m_acc_q += pq >>> 15;
    m_phase += phase_inc;
    m_cnt++;
    if (m_cnt == DECIM) begin
`ifdef DDC_ROUND_EN
      m_acc_i += DECIM / 2;
      m_acc_q += DECIM / 2;
`endif
      push_exp(int'(m_acc_i >>> SH), int'(m_acc_q >>> SH));
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] x);
    in_valid = 1'b1;
    rf_input = x;
    tick();
  endtask

  task automatic send_m(input logic signed [15:0] x);
    model_step(x);
    send(x);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    repeat (3) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge sys_clk) begin : monitor
    pair_t e;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("i_out", i_out, e.i);
        chk("q_out", q_out, e.q);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n0;

    // Reset held with activity on the inputs.
    rf_input = 16'sd1000;
    for (int k = 0; k < 6; k++) begin
      in_valid = k[0];
      tick();
    end
    @(negedge sys_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_i_out", i_out, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_overflow", overflow, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // DC input, zero increment: checks value and 3-cycle latency.
    phase_inc = '0;
    push_exp(DC_I, 0);
    repeat (4) send(16'sd16384);
    in_valid = 1'b0;
    @(negedge sys_clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge sys_clk);
    chk("lat_cycle2", out_valid, 0);
    @(negedge sys_clk);
    chk("lat_cycle3", out_valid, 1);
    drain("dc_drain");

    // fs/4 mix.
    phase_inc = 32'h4000_0000;
    push_exp(FS_I, FS_Q);
    repeat (4) send(16'sd16384);
    drain("fs4_drain");

    // Increment of 3/4 turn, crossing the accumulator wrap.
    phase_inc = 32'hC000_0000;
    push_exp(FS_I, FS_Q);
    push_exp(FS_I, FS_Q);
    repeat (8) send(16'sd16384);
    drain("wrap_drain");

    // 1-on/1-off input gaps.
    phase_inc = '0;
    n0 = n_out;
    push_exp(DC_I, 0);
    push_exp(DC_I, 0);
    for (int k = 0; k < 8; k++) begin
      send(16'sd16384);
      idle(1);
    end
    drain("gap_drain");
    chk("gap_out_count", n_out - n0, 2);

    // Mid-block clear discards the partial block and rewinds phase.
    n0 = n_out;
    phase_inc = 32'h1234_5678;
    repeat (2) send(16'sd16384);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle(6);
    chk("clr_no_output", n_out - n0, 0);
    chk("clr_out_valid", out_valid, 0);
    phase_inc = '0;
    push_exp(DC_I, 0);
    repeat (4) send(16'sd16384);
    drain("clr_drain");

    // Backpressure across two dumps: first held, second dropped.
    out_ready = 1'b0;
    push_exp(DC_I, 0);
    repeat (4) send(16'sd16384);
    repeat (4) send(-16'sd8192);
    idle(4);
    @(negedge sys_clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_hold_i", i_out, DC_I);
    chk("bp_overflow", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge sys_clk);
    chk("ovf_cleared", overflow, 0);

    // Dump coinciding with out_ready: old consumed, new loaded, no overflow.
    push_exp(NEG_I, 0);
    repeat (4) send(-16'sd8192);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge sys_clk);
    chk("ready_dump_ovf", overflow, 0);
    drain("ready_dump_drain");

    // Random samples and increments against the reference model.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_phase = '0;
    m_acc_i = 0;
    m_acc_q = 0;
    m_cnt   = 0;
    n0 = n_out;
    for (int k = 0; k < 16; k++) begin
      phase_inc = $urandom();
      send_m(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain("rand_drain");
    chk("rand_out_count", n_out - n0, 4);
    chk("final_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
